// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target exposing four 8-bit registers
//
// Ports:
//   clk          system clock, at least 16x the SCL rate
//   rst_n        synchronous active-low reset
//   scl_i        bus SCL, asynchronous to clk
//   sda_i        bus SDA (wired-AND result), asynchronous to clk
//   sda_o        open-drain drive: 0 pulls SDA low, 1 releases it
//   regs_o       register file {reg3, reg2, reg1, reg0}
//   wr_strobe_o  one-clk pulse per byte written
//   wr_idx_o     register index belonging to wr_strobe_o
//   busy_o       high from address match until STOP or NACK

module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic [31:0] regs_o,
  output logic        wr_strobe_o,
  output logic [1:0]  wr_idx_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_RD_BYTE,
    S_RD_ACK,
    S_WAIT_STOP
  } state_t;

  // Two-flop synchronizers plus one history flop each for edge detection.
  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  state_t      r_state;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic [1:0]  r_ptr;
  logic        r_rw;
  // In the ACK states: set once the first falling edge (or master ACK) was seen.
  logic        r_ack_flag;
  logic        r_sda_o;
  logic [31:0] r_regs;
  logic        r_wr_strobe;
  logic [1:0]  r_wr_idx;
  logic        r_busy;

  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte_in;
  logic [7:0] w_cur_byte;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  // SCL must be high on both samples so an SDA change racing an SCL edge
  // is never mistaken for a bus condition.
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte_in  = {r_shift[6:0], r_sda_s2};
  assign w_cur_byte = r_regs[{r_ptr, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= 3'd0;
      r_shift     <= 8'h00;
      r_ptr       <= 2'd0;
      r_rw        <= 1'b0;
      r_ack_flag  <= 1'b0;
      r_sda_o     <= 1'b1;
      r_regs      <= 32'h0;
      r_wr_strobe <= 1'b0;
      r_wr_idx    <= 2'd0;
      r_busy      <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_start) begin
        r_state    <= S_ADDR;
        r_bitcnt   <= 3'd0;
        r_ptr      <= 2'd0;
        r_sda_o    <= 1'b1;
        r_ack_flag <= 1'b0;
      end else if (w_stop) begin
        r_state    <= S_IDLE;
        r_sda_o    <= 1'b1;
        r_busy     <= 1'b0;
        r_ack_flag <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte_in;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                // r_shift[6:0] holds address bits 7..1, SDA now is R/W.
                if (r_shift[6:0] == SLAVE_ADDR) begin
                  r_state    <= S_ADDR_ACK;
                  r_rw       <= r_sda_s2;
                  r_busy     <= 1'b1;
                  r_ack_flag <= 1'b0;
                end else begin
                  r_state <= S_WAIT_STOP;
                  r_busy  <= 1'b0;
                end
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_flag) begin
                r_sda_o    <= 1'b0;
                r_ack_flag <= 1'b1;
              end else begin
                r_ack_flag <= 1'b0;
                r_bitcnt   <= 3'd0;
                if (r_rw) begin
                  r_shift <= w_cur_byte;
                  r_sda_o <= w_cur_byte[7];
                  r_state <= S_RD_BYTE;
                end else begin
                  r_sda_o <= 1'b1;
                  r_state <= S_WR_BYTE;
                end
              end
            end
          end
          S_WR_BYTE: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte_in;
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_regs[{r_ptr, 3'b000} +: 8] <= w_byte_in;
                r_wr_strobe <= 1'b1;
                r_wr_idx    <= r_ptr;
                r_ptr       <= r_ptr + 2'd1;
                r_ack_flag  <= 1'b0;
                r_state     <= S_WR_ACK;
              end
            end
          end
          S_WR_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_flag) begin
                r_sda_o    <= 1'b0;
                r_ack_flag <= 1'b1;
              end else begin
                r_sda_o    <= 1'b1;
                r_ack_flag <= 1'b0;
                r_bitcnt   <= 3'd0;
                r_state    <= S_WR_BYTE;
              end
            end
          end
          S_RD_BYTE: begin
            // Bit 7 is already on the bus; seven falls shift out bits 6..0,
            // the eighth releases SDA for the master's ACK.
            if (w_scl_fall) begin
              if (r_bitcnt == 3'd7) begin
                r_sda_o    <= 1'b1;
                r_bitcnt   <= 3'd0;
                r_ack_flag <= 1'b0;
                r_state    <= S_RD_ACK;
              end else begin
                r_sda_o  <= r_shift[6];
                r_shift  <= {r_shift[6:0], 1'b0};
                r_bitcnt <= r_bitcnt + 3'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (w_scl_rise) begin
              if (!r_sda_s2) begin
                r_ptr      <= r_ptr + 2'd1;
                r_ack_flag <= 1'b1;
              end else begin
                r_sda_o <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_WAIT_STOP;
              end
            end else if (w_scl_fall && r_ack_flag) begin
              // Pointer was advanced on the ACK rise, so this is the next byte.
              r_ack_flag <= 1'b0;
              r_shift    <= w_cur_byte;
              r_sda_o    <= w_cur_byte[7];
              r_bitcnt   <= 3'd0;
              r_state    <= S_RD_BYTE;
            end
          end
          default: begin
            r_sda_o <= 1'b1;
          end
        endcase
      end
    end
  end

  assign sda_o       = r_sda_o;
  assign regs_o      = r_regs;
  assign wr_strobe_o = r_wr_strobe;
  assign wr_idx_o    = r_wr_idx;
  assign busy_o      = r_busy;

endmodule
